// File: rtl/norm_shift_decoder_pkg.sv
// Shared FPU add/sub constants and helpers used by the normalization shifter.
package norm_shift_decoder_pkg;

  localparam int unsigned SigWidth   = 26;
  localparam int unsigned ExpWidth   = 8;
  localparam int unsigned ShiftCodeW = 5;
  localparam int unsigned MaxShift   = 25;
  localparam int unsigned CoarseStep = 8;

  // Codes 26..31 cannot come from a well-formed priority codec.
  function automatic logic shift_illegal(input logic [ShiftCodeW-1:0] code);
    return code > ShiftCodeW'(MaxShift);
  endfunction

endpackage

// File: rtl/norm_shift_stage.sv
// One normalization pipeline stage: left-shift by Step*amt, register the result
// together with a side-band payload; holds everything while en is low.
module norm_shift_stage #(
  parameter int unsigned SW   = 26,
  parameter int unsigned AW   = 2,
  parameter int unsigned Step = 8,
  parameter int unsigned PW   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          valid_in,
  input  logic [AW-1:0] amt,
  input  logic [SW-1:0] sig_in,
  input  logic          zero_in,
  input  logic [PW-1:0] pass_in,
  output logic          valid_out,
  output logic [SW-1:0] sig_out,
  output logic [PW-1:0] pass_out
);

  localparam int unsigned MaxSh = Step * ((1 << AW) - 1);
  localparam int unsigned ShW   = $clog2(MaxSh + 1);

  logic [ShW-1:0] sh;
  logic [SW-1:0]  sig_d;
  logic           valid_q;
  logic [SW-1:0]  sig_q;
  logic [PW-1:0]  pass_q;

  assign sh = ShW'(amt) * ShW'(Step);

  always_comb begin
    sig_d = sig_in << sh;
    if (zero_in) begin
      sig_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      sig_q   <= '0;
      pass_q  <= '0;
    end else if (en) begin
      valid_q <= valid_in;
      sig_q   <= sig_d;
      pass_q  <= pass_in;
    end
  end

  assign valid_out = valid_q;
  assign sig_out   = sig_q;
  assign pass_out  = pass_q;

endmodule

// File: rtl/norm_shift_decoder.sv
// Two-stage normalization shifter: coarse byte shift, then fine shift plus
// exponent adjust with underflow / illegal-code handling. Global stall.
module norm_shift_decoder
  import norm_shift_decoder_pkg::*;
#(
  parameter int unsigned SW = SigWidth,
  parameter int unsigned EW = ExpWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Valid_i,
  output logic                  Ready_o,
  input  logic [ShiftCodeW-1:0] Shift_Bin_i,
  input  logic [SW-1:0]         Sig_i,
  input  logic [EW-1:0]         Exp_i,
  output logic                  Valid_o,
  input  logic                  Ready_i,
  output logic [SW-1:0]         Sig_o,
  output logic [EW-1:0]         Exp_o,
  output logic                  Uflow_o,
  output logic                  Err_o
);

  localparam int unsigned S1PW = EW + ShiftCodeW;
  localparam int unsigned S2PW = EW + 2;
  localparam int unsigned DW   = EW + 1;

  logic                  en;
  logic                  s1_valid;
  logic [SW-1:0]         s1_sig;
  logic [S1PW-1:0]       s1_pass;
  logic [EW-1:0]         s1_exp;
  logic [ShiftCodeW-1:0] s1_code;
  logic [DW-1:0]         diff;
  logic                  err;
  logic                  uflow;
  logic [EW-1:0]         exp_adj;

  // Every stage advances together; only a held output beat stalls the pipe.
  assign Ready_o = !Valid_o || Ready_i;
  assign en      = Ready_o;

  norm_shift_stage #(
    .SW   (SW),
    .AW   (2),
    .Step (CoarseStep),
    .PW   (S1PW)
  ) u_stage_coarse (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .valid_in  (Valid_i),
    .amt       (Shift_Bin_i[4:3]),
    .sig_in    (Sig_i),
    .zero_in   (1'b0),
    .pass_in   ({Exp_i, Shift_Bin_i}),
    .valid_out (s1_valid),
    .sig_out   (s1_sig),
    .pass_out  (s1_pass)
  );

  assign s1_exp  = s1_pass[S1PW-1:ShiftCodeW];
  assign s1_code = s1_pass[ShiftCodeW-1:0];

  // Borrow out of the EW+1 bit difference flags underflow; illegal code wins.
  always_comb begin
    err     = shift_illegal(s1_code);
    diff    = {1'b0, s1_exp} - DW'(s1_code);
    uflow   = !err && diff[EW];
    exp_adj = diff[EW-1:0];
    if (err) begin
      exp_adj = s1_exp;
    end else if (uflow) begin
      exp_adj = '0;
    end
  end

  norm_shift_stage #(
    .SW   (SW),
    .AW   (3),
    .Step (1),
    .PW   (S2PW)
  ) u_stage_fine (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .valid_in  (s1_valid),
    .amt       (s1_code[2:0]),
    .sig_in    (s1_sig),
    .zero_in   (err || uflow),
    .pass_in   ({exp_adj, uflow, err}),
    .valid_out (Valid_o),
    .sig_out   (Sig_o),
    .pass_out  ({Exp_o, Uflow_o, Err_o})
  );

endmodule

// File: tb/tb_norm_shift_decoder.sv
// Self-checking bench for norm_shift_decoder: directed corner beats, stall and
// reset scenarios, then randomized traffic against an in-order reference queue.
module tb_norm_shift_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        Valid_i;
  logic        Ready_o;
  logic [4:0]  Shift_Bin_i;
  logic [25:0] Sig_i;
  logic [7:0]  Exp_i;
  logic        Valid_o;
  logic        Ready_i;
  logic [25:0] Sig_o;
  logic [7:0]  Exp_o;
  logic        Uflow_o;
  logic        Err_o;
  logic [35:0] outs;

  int n_checks = 0;
  int n_fails  = 0;
  int n_out    = 0;

  logic [35:0] exp_q[$];
  bit          hold_pend = 1'b0;
  logic [36:0] held;

  always #5 clk = ~clk;

  assign outs = {Err_o, Uflow_o, Exp_o, Sig_o};

  norm_shift_decoder #(
    .SW (26),
    .EW (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .Valid_i     (Valid_i),
    .Ready_o     (Ready_o),
    .Shift_Bin_i (Shift_Bin_i),
    .Sig_i       (Sig_i),
    .Exp_i       (Exp_i),
    .Valid_o     (Valid_o),
    .Ready_i     (Ready_i),
    .Sig_o       (Sig_o),
    .Exp_o       (Exp_o),
    .Uflow_o     (Uflow_o),
    .Err_o       (Err_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Result packed as {err, uflow, exp, sig}.
  function automatic logic [35:0] ref_beat(input logic [25:0] s, input logic [7:0] e,
                                           input logic [4:0] sh);
    int unsigned shi = sh;
    int unsigned ei  = e;
    logic [25:0] ns;
    logic [7:0]  ne;
    if (shi > 25) return {1'b1, 1'b0, e, 26'd0};
    if (shi > ei) return {1'b0, 1'b1, 8'd0, 26'd0};
    ns = s << shi;
    ne = 8'(ei - shi);
    return {2'b00, ne, ns};
  endfunction

  task automatic drive(input bit v, input logic [25:0] s, input logic [7:0] e,
                       input logic [4:0] sh);
    Valid_i     = v;
    Sig_i       = s;
    Exp_i       = e;
    Shift_Bin_i = sh;
  endtask

  // Called at a falling edge with inputs set; checks this cycle, advances one clock.
  task automatic tick(output bit acc);
    bit fin, fout;
    #1;
    check_eq("ready_o", Ready_o, !Valid_o || Ready_i);
    if (hold_pend) check_eq("hold", {Valid_o, outs}, held);
    fin       = Valid_i && Ready_o && !rst;
    fout      = Valid_o && Ready_i && !rst;
    hold_pend = Valid_o && !Ready_i && !rst;
    held      = {Valid_o, outs};
    if (fout) begin
      if (exp_q.size() == 0) begin
        check_eq("stale_beat", Valid_o, 0);
      end else begin
        check_eq("beat", outs, exp_q.pop_front());
        n_out++;
      end
    end
    if (fin) exp_q.push_back(ref_beat(Sig_i, Exp_i, Shift_Bin_i));
    acc = fin;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      hold_pend = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic directed(input string tag, input logic [25:0] s, input logic [7:0] e,
                          input logic [4:0] sh, input logic [35:0] want);
    bit a;
    Ready_i = 1'b1;
    drive(1'b1, s, e, sh);
    tick(a);
    check_eq({tag, "_acc"}, a, 1);
    drive(1'b0, '0, '0, '0);
    check_eq({tag, "_lat1"}, Valid_o, 0);
    tick(a);
    check_eq({tag, "_lat2"}, Valid_o, 1);
    check_eq(tag, outs, want);
    tick(a);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit          a;
    int          idx;
    int          base;
    logic [25:0] bs[8];
    logic [7:0]  be[8];
    logic [4:0]  bh[8];

    rst = 1'b1;
    Ready_i = 1'b0;
    drive(1'b0, '0, '0, '0);
    @(negedge clk);
    tick(a);
    tick(a);
    rst = 1'b0;
    check_eq("rst_valid", Valid_o, 0);
    check_eq("rst_data", outs, 0);
    check_eq("rst_ready", Ready_o, 1);

    directed("abc_sh13", 26'h0000ABC, 8'd100, 5'd13, {2'b00, 8'd87, 26'h1578000});
    directed("uflow_sh25", 26'h3FFFFFF, 8'd10, 5'd25, {2'b01, 8'd0, 26'd0});
    directed("err_sh27", 26'h1234567, 8'd50, 5'd27, {2'b10, 8'd50, 26'd0});
    directed("zero_sh", 26'h2000000, 8'd0, 5'd0, {2'b00, 8'd0, 26'h2000000});
    directed("sh_eq_exp", 26'h0000001, 8'd25, 5'd25, {2'b00, 8'd0, 26'h2000000});

    // Eight back-to-back beats with the sink stalled in cycles 3..5.
    for (int i = 0; i < 8; i++) begin
      bs[i] = 26'($urandom);
      be[i] = 8'($urandom_range(0, 255));
      bh[i] = 5'($urandom_range(0, 25));
    end
    base = n_out;
    idx  = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      Ready_i = !(cyc >= 3 && cyc <= 5);
      if (idx < 8) drive(1'b1, bs[idx], be[idx], bh[idx]);
      else drive(1'b0, '0, '0, '0);
      if (cyc >= 3 && cyc <= 5) begin
        #1;
        check_eq("stall_ready", Ready_o, 0);
      end
      tick(a);
      if (a) idx++;
    end
    check_eq("b2b_accepted", idx, 8);
    check_eq("b2b_emitted", n_out - base, 8);
    check_eq("b2b_empty", exp_q.size(), 0);

    // Reset with two beats in flight.
    Ready_i = 1'b1;
    drive(1'b1, 26'h0000123, 8'd40, 5'd3);
    tick(a);
    drive(1'b1, 26'h0000456, 8'd60, 5'd9);
    tick(a);
    Ready_i = 1'b0;
    rst = 1'b1;
    drive(1'b0, '0, '0, '0);
    tick(a);
    rst = 1'b0;
    check_eq("flush_valid", Valid_o, 0);
    check_eq("flush_ready", Ready_o, 1);
    Ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(a);
      check_eq("flush_idle", Valid_o, 0);
    end

    // Randomized traffic with random backpressure.
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [4:0] sh;
      logic [7:0] e;
      sh = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(26, 31)) : 5'($urandom_range(0, 25));
      e  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom);
      Ready_i = ($urandom_range(0, 9) < 7);
      drive($urandom_range(0, 3) != 0, 26'($urandom), e, sh);
      tick(a);
    end

    Ready_i = 1'b1;
    drive(1'b0, '0, '0, '0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick(a);
    check_eq("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
